// File: rtl/if_prefetch_unit_pkg.sv
// Shared core configuration for the instruction-fetch stage: address map,
// buffer depth, NOP encoding, fetch FSM states and the buffered entry format.
package if_prefetch_unit_pkg;

  localparam int XLEN          = 32;
  localparam int PERF_CNT_LEN  = 64;
  localparam int IF_FIFO_DEPTH = 4;

  localparam logic [XLEN-1:0] IF_BASE_ADDR = 32'h1000_0000;
  localparam logic [XLEN-1:0] IF_MAX_ADDR  = 32'h1000_3FFF;
  localparam logic [XLEN-1:0] IF_INC       = 32'd4;
  localparam logic [XLEN-1:0] IF_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_DRAIN = 2'd2,
    IF_HALT  = 2'd3
  } if_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } if_entry_t;

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// Synchronous prefetch buffer of if_entry_t. Flush dominates push and pop;
// a push into a full buffer is accepted only together with a pop.
module if_fifo
  import if_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = IF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  if_entry_t              push_data,
  input  logic                   pop,
  input  logic                   flush,
  output if_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if_entry_t     mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_pop_s  = pop && !empty && !flush;
  assign do_push_s = push && !flush && (!full || do_pop_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Entry storage; needs no reset because count_r qualifies every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// RV32 instruction prefetch stage: single-outstanding imem fetch into a small
// buffer feeding the decoder. Optional stall counter under IF_PERF_CNT_EN.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int              FIFO_DEPTH = IF_FIFO_DEPTH,
  parameter logic [XLEN-1:0] BASE_ADDR  = IF_BASE_ADDR,
  parameter logic [XLEN-1:0] MAX_ADDR   = IF_MAX_ADDR,
  parameter logic [XLEN-1:0] PC_INC     = IF_INC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault
`ifdef IF_PERF_CNT_EN
  ,
  output logic [PERF_CNT_LEN-1:0] if_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_t       state_r, state_s;
  logic [XLEN-1:0] pc_r, pc_s;
  logic            pc_wrap_r, pc_wrap_s;
  logic [XLEN-1:0] redir_pc_r, redir_pc_s;
  logic            push_s;
  if_entry_t       push_entry_s;
  if_entry_t       fifo_head_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [CW-1:0]   fifo_count_s;

  function automatic logic pc_in_range(input logic [XLEN-1:0] pc);
    return (pc >= BASE_ADDR) && (pc <= MAX_ADDR);
  endfunction

  if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (if_valid && if_ready),
    .flush     (redirect_valid),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign imem_addr = pc_r;
  assign if_valid  = !fifo_empty_s;
  assign if_instr  = if_valid ? fifo_head_s.instr : {XLEN{1'b0}};
  assign if_pc     = if_valid ? fifo_head_s.pc    : {XLEN{1'b0}};
  assign if_fault  = if_valid && fifo_head_s.fault;

  // Next-state, request and push decode; a redirect overrides the per-state result.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    pc_wrap_s    = pc_wrap_r;
    redir_pc_s   = redir_pc_r;
    imem_req     = 1'b0;
    push_s       = 1'b0;
    push_entry_s = '{instr: imem_rdata, pc: pc_r, fault: 1'b0};
    case (state_r)
      IF_IDLE: state_s = IF_REQ;
      IF_REQ: begin
        if (pc_wrap_r || !pc_in_range(pc_r)) begin
          if (!fifo_full_s) begin
            push_s       = 1'b1;
            push_entry_s = '{instr: IF_NOP_INSTR, pc: pc_r, fault: 1'b1};
            state_s      = IF_HALT;
          end else begin
            state_s = IF_REQ;
          end
        end else if (fifo_count_s < CW'(FIFO_DEPTH)) begin
          // Only one request is ever in flight, so one free slot suffices.
          imem_req = 1'b1;
          if (imem_ack) begin
            push_s            = 1'b1;
            {pc_wrap_s, pc_s} = {1'b0, pc_r} + {1'b0, PC_INC};
          end else begin
            push_s = 1'b0;
          end
        end else begin
          imem_req = 1'b0;
        end
      end
      IF_DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_s = IF_REQ;
          pc_s    = redir_pc_r;
        end else begin
          state_s = IF_DRAIN;
        end
      end
      IF_HALT: state_s = IF_HALT;
      default: state_s = IF_IDLE;
    endcase

    if (redirect_valid) begin
      push_s     = 1'b0;
      pc_wrap_s  = 1'b0;
      redir_pc_s = {redirect_addr[XLEN-1:2], 2'b00};
      if (imem_req && !imem_ack) begin
        // Keep the old address on the bus until the memory answers.
        state_s = IF_DRAIN;
        pc_s    = pc_r;
      end else begin
        state_s = IF_REQ;
        pc_s    = {redirect_addr[XLEN-1:2], 2'b00};
      end
    end else begin
      redir_pc_s = redir_pc_r;
    end
  end

  // Fetch FSM and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IF_IDLE;
      pc_r       <= BASE_ADDR;
      pc_wrap_r  <= 1'b0;
      redir_pc_r <= BASE_ADDR;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      pc_wrap_r  <= pc_wrap_s;
      redir_pc_r <= redir_pc_s;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [PERF_CNT_LEN-1:0] stall_cnt_r;

  // Cycles the decoder is starved while fetch is still live.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {PERF_CNT_LEN{1'b0}};
    end else if (fifo_empty_s && (state_r != IF_HALT)) begin
      stall_cnt_r <= stall_cnt_r + PERF_CNT_LEN'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign if_stall_cnt = stall_cnt_r;
`endif

endmodule
